// File: rtl/divider_ratio_controller.sv
// divider_ratio_controller: mod-N period counter that drives a near-50% duty
// divided enable (div_out) and a period-start tick, with a ratio handshake.
//
// Ports:
//   clock, reset      single clock; synchronous active-high reset
//   enable            run request; a running period always completes
//   cfg_valid/ready   ratio handshake; ready drops while a ratio is pending
//   cfg_n             requested ratio (legal 2 .. 2^N_WIDTH-1)
//   cfg_err           one-cycle pulse after an illegal ratio (0 or 1) transfer
//   div_out, tick     divided output and period-start pulse
//   pending           a legal ratio waits for the next period boundary
//   cur_n             ratio currently in effect
module divider_ratio_controller #(
    parameter int N_WIDTH   = 5,
    parameter int DEFAULT_N = 9
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               enable,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [N_WIDTH-1:0] cfg_n,
    output logic               cfg_err,
    output logic               div_out,
    output logic               tick,
    output logic               pending,
    output logic [N_WIDTH-1:0] cur_n
);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    localparam logic [N_WIDTH-1:0] DEF_N = N_WIDTH'(DEFAULT_N);
    localparam logic [N_WIDTH-1:0] ONE   = N_WIDTH'(1);

    state_t             state_q;
    state_t             state_d;
    logic [N_WIDTH-1:0] cnt_q;
    logic [N_WIDTH-1:0] cnt_d;
    logic [N_WIDTH-1:0] cur_n_q;
    logic [N_WIDTH-1:0] pend_n_q;
    logic               pending_q;
    logic               cfg_err_q;

    logic               xfer;
    logic               legal;
    logic               boundary;
    logic [N_WIDTH:0]   half;

    assign xfer     = cfg_valid && !pending_q;
    assign legal    = cfg_n > ONE;
    assign boundary = (state_q == RUN) && (cnt_q == cur_n_q - ONE);

    // One extra bit so (cur_n+1) does not wrap at the largest ratio.
    assign half = ({1'b0, cur_n_q} + (N_WIDTH + 1)'(1)) >> 1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (enable) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (boundary) begin
                    cnt_d = '0;
                    if (!enable) begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // A transfer needs !pending, so it never collides with applying a
    // pending ratio; a transfer on a boundary waits one more period.
    always_ff @(posedge clock) begin
        if (reset) begin
            cur_n_q   <= DEF_N;
            pend_n_q  <= DEF_N;
            pending_q <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            cfg_err_q <= xfer && !legal;
            if (boundary && pending_q) begin
                cur_n_q   <= pend_n_q;
                pending_q <= 1'b0;
            end
            if (xfer && legal) begin
                if (state_q == RUN) begin
                    pend_n_q  <= cfg_n;
                    pending_q <= 1'b1;
                end else begin
                    cur_n_q <= cfg_n;
                end
            end
        end
    end

    assign cfg_ready = !pending_q;
    assign cfg_err   = cfg_err_q;
    assign pending   = pending_q;
    assign cur_n     = cur_n_q;
    assign div_out   = (state_q == RUN) && ({1'b0, cnt_q} < half);
    assign tick      = (state_q == RUN) && (cnt_q == '0);

endmodule
